// File: rtl/uart_frame_sched.sv
// Frames PCM samples and message bytes onto one byte-serial UART as SYNC/TAG/payload
// packets, with a small PCM FIFO in front and a go/ready byte handshake behind.
module uart_frame_sched #(
    parameter int         FRAME_LEN  = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter int         MSG_MAX    = 15,
    parameter logic [7:0] SYNC       = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pcm_stb,
    input  logic [7:0] pcm_data,
    input  logic       msg_valid,
    input  logic [7:0] msg_data,
    input  logic       msg_last,
    output logic       msg_ready,
    output logic [7:0] uart_char,
    output logic       uart_go,
    input  logic       uart_ready,
    output logic       pcm_overrun,
    input  logic       ovr_clr,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] HALF_LVL = (AW+1)'(FIFO_DEPTH / 2);
    localparam logic [7:0]  TAG_PCM  = 8'h00;
    localparam logic [7:0]  TAG_MSG  = 8'h01;
    localparam logic [7:0]  TAG_CONT = 8'h02;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_TAG, S_PCM, S_MSG} state_t;
    typedef enum logic [1:0] {B_LOAD, B_GO, B_REL} bstate_t;

    // Payload must never alias the frame marker on the wire.
    function automatic logic [7:0] clamp(input logic [7:0] b);
        return (b == SYNC) ? (SYNC ^ 8'h01) : b;
    endfunction

    state_t      state;
    bstate_t     bstate;
    logic        kind_msg;
    logic        cont;
    logic        last_sent;
    logic [7:0]  cnt;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] fill;
    logic        empty, full, pop, push_ok, drop;

    logic        can_load, byte_done, load_en, take;
    logic [7:0]  load_byte;

    assign empty     = (fill == '0);
    assign full      = (fill == FULL_LVL);
    assign push_ok   = pcm_stb && (!full || pop);
    assign drop      = pcm_stb && full && !pop;
    assign can_load  = (bstate == B_LOAD) && uart_ready;
    assign byte_done = (bstate == B_REL) && uart_ready;
    assign busy      = (state != S_IDLE);

    always_comb begin
        load_en   = 1'b0;
        load_byte = SYNC;
        pop       = 1'b0;
        take      = 1'b0;
        if (can_load) begin
            case (state)
                S_SYNC: load_en = 1'b1;
                S_TAG: begin
                    load_en   = 1'b1;
                    load_byte = !kind_msg ? TAG_PCM : (cont ? TAG_CONT : TAG_MSG);
                end
                S_PCM: if (!empty) begin
                    load_en   = 1'b1;
                    pop       = 1'b1;
                    load_byte = mem[rd_ptr];
                end
                S_MSG: if (msg_valid) begin
                    load_en   = 1'b1;
                    take      = 1'b1;
                    load_byte = clamp(msg_data);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= clamp(pcm_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            pcm_overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + (AW+1)'(push_ok) - (AW+1)'(pop);
            // A drop in the same cycle as a clear wins, so no overrun goes unseen.
            if (drop)         pcm_overrun <= 1'b1;
            else if (ovr_clr) pcm_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            bstate    <= B_LOAD;
            kind_msg  <= 1'b0;
            cont      <= 1'b0;
            last_sent <= 1'b0;
            cnt       <= 8'd0;
            uart_char <= 8'd0;
            uart_go   <= 1'b0;
            msg_ready <= 1'b0;
        end else begin
            msg_ready <= take;

            if (load_en) begin
                uart_char <= load_byte;
                uart_go   <= 1'b1;
                bstate    <= B_GO;
            end else begin
                case (bstate)
                    B_GO:    if (!uart_ready) begin
                                 uart_go <= 1'b0;
                                 bstate  <= B_REL;
                             end
                    B_REL:   if (uart_ready) bstate <= B_LOAD;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    // A strobe arriving now counts as pending PCM, so PCM wins ties.
                    if (pcm_stb || !empty) begin
                        kind_msg <= 1'b0;
                        state    <= S_SYNC;
                    end else if (msg_valid) begin
                        kind_msg <= 1'b1;
                        state    <= S_SYNC;
                    end
                end
                S_SYNC: if (byte_done) state <= S_TAG;
                S_TAG: begin
                    if (load_en) cnt <= 8'd0;
                    if (byte_done) state <= kind_msg ? S_MSG : S_PCM;
                end
                S_PCM: begin
                    if (load_en) cnt <= cnt + 8'd1;
                    if (byte_done && cnt == 8'(FRAME_LEN)) begin
                        if (msg_valid) begin
                            kind_msg <= 1'b1;
                            state    <= S_SYNC;
                        end else if (!empty) begin
                            kind_msg <= 1'b0;
                            state    <= S_SYNC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_MSG: begin
                    if (load_en) begin
                        cnt       <= cnt + 8'd1;
                        last_sent <= msg_last;
                    end else if (can_load && !empty) begin
                        // Source stalled while PCM waits: yield and resume later.
                        cont     <= 1'b1;
                        kind_msg <= 1'b0;
                        state    <= S_SYNC;
                    end else if (byte_done &&
                                 (last_sent || cnt == 8'(MSG_MAX) || fill >= HALF_LVL)) begin
                        cont     <= !last_sent;
                        kind_msg <= 1'b0;
                        state    <= empty ? S_IDLE : S_SYNC;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench: serializer model logs the wire, message source model feeds bytes,
// and each test compares the logged bytes against hand-built expected frames.
module tb_uart_frame_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       pcm_stb;
    logic [7:0] pcm_data;
    logic       msg_valid, msg_last, msg_ready;
    logic [7:0] msg_data;
    logic [7:0] uart_char;
    logic       uart_go, uart_ready;
    logic       pcm_overrun, ovr_clr, busy;

    int nchk = 0;
    int npass = 0;

    logic [7:0] wlog [512];
    int         wcnt;
    logic       ser_en;
    int         long_req, long_seen;

    logic [7:0] mbuf [32];
    int         mlen, mstart, mseen, midx, rdy_cnt;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_frame_sched dut (
        .clk(clk), .rst(rst), .pcm_stb(pcm_stb), .pcm_data(pcm_data),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last),
        .msg_ready(msg_ready), .uart_char(uart_char), .uart_go(uart_go),
        .uart_ready(uart_ready), .pcm_overrun(pcm_overrun), .ovr_clr(ovr_clr),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Serializer: accepts on go, holds ready low 20 cycles (200 once on request).
    initial begin
        int h;
        uart_ready = 1'b1;
        wcnt = 0;
        long_seen = 0;
        forever begin
            @(posedge clk); #1;
            if (ser_en && uart_ready && uart_go) begin
                if (wcnt < 512) wlog[wcnt] = uart_char;
                wcnt++;
                uart_ready = 1'b0;
                h = (long_req != long_seen) ? 200 : 20;
                long_seen = long_req;
                repeat (h) @(posedge clk);
                #1 uart_ready = 1'b1;
            end
        end
    end

    // Message source: advances one byte per msg_ready pulse.
    initial begin
        msg_valid = 1'b0; msg_data = 8'd0; msg_last = 1'b0;
        midx = 0; mseen = 0; rdy_cnt = 0;
        forever begin
            @(negedge clk);
            if (msg_ready) begin
                rdy_cnt++;
                midx++;
            end
            if (mstart != mseen) begin
                mseen = mstart;
                midx  = 0;
            end
            msg_valid = (midx < mlen);
            msg_data  = (midx < 32) ? mbuf[midx] : 8'd0;
            msg_last  = (midx == mlen - 1);
        end
    end

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        pcm_stb = 1'b1; pcm_data = d;
        @(negedge clk);
        pcm_stb = 1'b0;
    endtask

    task automatic push_run(input logic [7:0] d0, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            push(8'(d0 + i));
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic exp_frame(input logic [7:0] tag, input logic [7:0] d0, input int n);
        exp_q.push_back(8'hFF);
        exp_q.push_back(tag);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(d0 + i));
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 3000) begin @(negedge clk); c++; end
        chk(tag, busy, 1'b0);
    endtask

    task automatic frame_check(input string tag, input int base);
        int c = 0;
        while (wcnt < base + exp_q.size() && c < 6000) begin @(negedge clk); c++; end
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), wlog[base + i], exp_q[i]);
        wait_idle({tag, "_idle"});
        repeat (30) @(negedge clk);
        chk({tag, "_count"}, wcnt - base, exp_q.size());
    endtask

    initial begin
        int base, r0, c;
        rst = 1'b1; pcm_stb = 1'b0; pcm_data = 8'd0; ovr_clr = 1'b0;
        ser_en = 1'b1; long_req = 0; mstart = 0; mlen = 0;
        repeat (3) @(negedge clk);
        chk("rst_go", uart_go, 1'b0);
        chk("rst_char", uart_char, 8'd0);
        chk("rst_msg_ready", msg_ready, 1'b0);
        chk("rst_ovr", pcm_overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Plain PCM frame
        base = wcnt; exp_q = {};
        exp_frame(8'h00, 8'h10, 16);
        push_run(8'h10, 16, 30);
        frame_check("pcm1", base);
        chk("pcm1_ovr", pcm_overrun, 1'b0);

        // 0xFF sample clamped
        base = wcnt; exp_q = {};
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hFE);
        for (int i = 0; i < 15; i++) exp_q.push_back(8'(8'h20 + i));
        push(8'hFF);
        repeat (30) @(negedge clk);
        push_run(8'h20, 15, 30);
        frame_check("pcmff", base);

        // Single 0xFF message byte with last
        base = wcnt; exp_q = {}; r0 = rdy_cnt;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
        @(posedge clk); #2;
        mbuf[0] = 8'hFF; mlen = 1; mstart++;
        frame_check("msgff", base);
        chk("msgff_rdy", rdy_cnt - r0, 1);

        // 20-byte message split at MSG_MAX
        base = wcnt; exp_q = {}; r0 = rdy_cnt;
        exp_frame(8'h01, 8'h30, 15);
        exp_frame(8'h02, 8'h3F, 5);
        @(posedge clk); #2;
        for (int i = 0; i < 20; i++) mbuf[i] = 8'(8'h30 + i);
        mlen = 20; mstart++;
        frame_check("msg20", base);
        chk("msg20_rdy", rdy_cnt - r0, 20);

        // Overrun while serializer is stalled on the SYNC byte
        base = wcnt; exp_q = {};
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 12; i++) exp_q.push_back(8'(8'h50 + i));
        long_req++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pcm_stb = 1'b1; pcm_data = 8'(8'h40 + i);
        end
        @(negedge clk);
        pcm_stb = 1'b0;
        chk("ovr_set", pcm_overrun, 1'b1);
        pcm_stb = 1'b1; pcm_data = 8'h4A; ovr_clr = 1'b1;
        @(negedge clk);
        pcm_stb = 1'b0; ovr_clr = 1'b0;
        chk("ovr_clr_vs_drop", pcm_overrun, 1'b1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_cleared", pcm_overrun, 1'b0);
        c = 0;
        while (wcnt < base + 3 && c < 1000) begin @(negedge clk); c++; end
        push_run(8'h50, 12, 30);
        frame_check("ovr", base);
        chk("ovr_after", pcm_overrun, 1'b0);

        // PCM and message arrive together: PCM first, message right after
        base = wcnt; exp_q = {}; r0 = rdy_cnt;
        exp_frame(8'h00, 8'h70, 16);
        exp_frame(8'h01, 8'h60, 2);
        @(posedge clk); #2;
        mbuf[0] = 8'h60; mbuf[1] = 8'h61; mlen = 2; mstart++;
        @(negedge clk);
        pcm_stb = 1'b1; pcm_data = 8'h70;
        @(negedge clk);
        pcm_stb = 1'b0;
        repeat (30) @(negedge clk);
        push_run(8'h71, 15, 30);
        frame_check("tie", base);
        chk("tie_rdy", rdy_cnt - r0, 2);

        // Reset while go is asserted
        ser_en = 1'b0;
        push(8'h80);
        c = 0;
        while (!uart_go && c < 20) begin @(negedge clk); c++; end
        chk("pre_rst_go", uart_go, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_go", uart_go, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_char", uart_char, 8'd0);
        @(negedge clk);
        rst = 1'b0; ser_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", busy, 1'b0);
        base = wcnt; exp_q = {};
        exp_frame(8'h00, 8'h90, 16);
        push_run(8'h90, 16, 30);
        frame_check("post_rst", base);
        chk("post_rst_ovr", pcm_overrun, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
